// File: rtl/adc_deser_pkg.sv
// adc_deser_pkg: shared defaults and helpers for the serial ADC deserialiser.
//   DefaultWidth  - default bits per ADC word
//   DefaultClkDiv - default system clocks per i2sclk period
//   BitCntW       - bit-counter width for the default word size
//   cnt_width()   - counter width for a modulus, never less than one bit
package adc_deser_pkg;

  localparam int unsigned DefaultWidth  = 8;
  localparam int unsigned DefaultClkDiv = 8;

  // A modulus of 1 still needs a one-bit register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BitCntW = cnt_width(DefaultWidth);

endpackage

// File: rtl/i2s_bit_clk_div.sv
// i2s_bit_clk_div: divides the system clock down to the ADC bit clock.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   i2sclk   out  registered bit clock, 50% duty, period CLK_DIV clocks
//   rise_stb out  high in the clk cycle whose edge takes i2sclk 0->1
module i2s_bit_clk_div
  import adc_deser_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic clk,
  input  logic rst,
  output logic i2sclk,
  output logic rise_stb
);

  localparam int unsigned Half = CLK_DIV / 2;
  localparam int unsigned CntW = cnt_width(Half);

  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : gen_bad_div
    $error("CLK_DIV must be even and at least 2");
  end

  logic [CntW-1:0] cnt_q;
  logic            i2sclk_q;
  logic            term;

  assign term = (cnt_q == CntW'(Half - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      i2sclk_q <= 1'b0;
    end else if (term) begin
      cnt_q    <= '0;
      i2sclk_q <= ~i2sclk_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign i2sclk   = i2sclk_q;
  // Terminal count while low: this edge produces the rising edge.
  assign rise_stb = term & ~i2sclk_q;

endmodule

// File: rtl/adc_serial_deser.sv
// adc_serial_deser: deserialises the 1-bit ADC stream into parallel words.
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   adc_serial_in    in   serial data, sampled on i2sclk rising edges
//   i2sclk           out  bit clock to the ADC
//   spi_parallel_out out  last completed word, held until the next completes
//   finished         out  one-clk pulse when spi_parallel_out updates
// Build option: define LSB_FIRST_EN for an LSB-first stream (default MSB first).
// Framing is free-running: a word boundary every WIDTH bits counted from reset.
module adc_serial_deser
  import adc_deser_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_serial_in,
  output logic             i2sclk,
  output logic [WIDTH-1:0] spi_parallel_out,
  output logic             finished
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  if (WIDTH < 2) begin : gen_bad_width
    $error("WIDTH must be at least 2");
  end

  logic rise_stb;

  i2s_bit_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i2sclk   (i2sclk),
    .rise_stb (rise_stb)
  );

  // Only WIDTH-1 bits are retained: the bit that would be shifted out of a full
  // WIDTH-bit register can never reach a completed word.
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-2:0] shift_d;
  logic [CntW-1:0]  bit_cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             finished_q;
  logic             last_bit;

  always_comb begin
    word_d  = '0;
    shift_d = '0;
`ifdef LSB_FIRST_EN
    word_d  = {adc_serial_in, shift_q};
    shift_d = word_d[WIDTH-1:1];
`else
    word_d  = {shift_q, adc_serial_in};
    shift_d = word_d[WIDTH-2:0];
`endif
  end

  assign last_bit = (bit_cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      out_q      <= '0;
      finished_q <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      if (rise_stb) begin
        shift_q <= shift_d;
        if (last_bit) begin
          out_q      <= word_d;
          finished_q <= 1'b1;
          bit_cnt_q  <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
      end
    end
  end

  assign spi_parallel_out = out_q;
  assign finished         = finished_q;

endmodule

// File: tb/tb_adc_serial_deser.sv
module tb_adc_serial_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adc_serial_in = 1'b0;
  logic       i2sclk;
  logic [7:0] spi_parallel_out;
  logic       finished;

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;
  int fin_double = 0;
  logic       fin_prev = 1'b0;
  logic [7:0] fin_word = 8'h00;

  always #5 clk = ~clk;

  adc_serial_deser #(
    .WIDTH   (8),
    .CLK_DIV (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .adc_serial_in    (adc_serial_in),
    .i2sclk           (i2sclk),
    .spi_parallel_out (spi_parallel_out),
    .finished         (finished)
  );

  // Pulse monitor: counts finished pulses and any pulse longer than one clk.
  always @(negedge clk) begin
    if (finished === 1'b1) begin
      fin_cnt++;
      fin_word = spi_parallel_out;
      if (fin_prev === 1'b1) fin_double++;
    end
    fin_prev = finished;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word as it should appear on the output for bits sent in the order w[7]..w[0].
  function automatic logic [7:0] exp_word(input logic [7:0] w);
    logic [7:0] r;
`ifdef LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic wait_level(input logic lvl);
    int n = 0;
    while (i2sclk !== lvl && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check_eq("i2sclk_wait", {31'b0, i2sclk}, {31'b0, lvl});
  endtask

  // Sends bits w[7], w[6], ... (nbits of them); call while i2sclk is low, just after
  // a fall or reset release. With glitch set, the line toggles away from the bit
  // value except around the sampling edge.
  task automatic send_bits(input logic [7:0] w, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = w[7-i];
      adc_serial_in = b;
      if (glitch) begin
        @(negedge clk);
        adc_serial_in = ~b;
        @(negedge clk);
        adc_serial_in = b;
      end
      wait_level(1'b1);
      if (glitch) adc_serial_in = ~b;
      wait_level(1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset held for two clocks.
    rst = 1'b1;
    adc_serial_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_i2sclk", {31'b0, i2sclk}, 32'd0);
    check_eq("rst_out", {24'b0, spi_parallel_out}, 32'h00);
    check_eq("rst_finished", {31'b0, finished}, 32'd0);
    rst = 1'b0;

    // First rise 4 clocks after release; it samples the first bit (1) of 0xA7.
    n = 0;
    while (i2sclk !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_rise_latency", n, 32'd4);
    wait_level(1'b0);

    // Remaining bits of 1010_0111: six more, then check, then the last one.
    send_bits(8'h4E, 6, 1'b0);
    check_eq("pre_word_out", {24'b0, spi_parallel_out}, 32'h00);
    check_eq("pre_word_fin", fin_cnt, 32'd0);
    send_bits(8'h80, 1, 1'b0);
    check_eq("word1_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'hA7)});
    check_eq("word1_fin_cnt", fin_cnt, 32'd1);
    check_eq("word1_fin_word", {24'b0, fin_word}, {24'b0, exp_word(8'hA7)});

    // Back-to-back 0010_1001; output holds 0xA7 while shifting.
    send_bits(8'h29, 4, 1'b0);
    check_eq("hold_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'hA7)});
    send_bits(8'h90, 4, 1'b0);
    check_eq("word2_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'h29)});
    check_eq("word2_fin_cnt", fin_cnt, 32'd2);

    // Reset after five bits; partial bits are discarded.
    send_bits(8'hFF, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out", {24'b0, spi_parallel_out}, 32'h00);
    check_eq("midrst_i2sclk", {31'b0, i2sclk}, 32'd0);
    send_bits(8'hD6, 8, 1'b0);
    check_eq("word3_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'hD6)});
    check_eq("word3_fin_cnt", fin_cnt, 32'd3);

    // A different word first so the glitch test shows a real update.
    send_bits(8'h5A, 8, 1'b0);
    check_eq("word4_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'h5A)});
    send_bits(8'hD6, 8, 1'b1);
    check_eq("glitch_out", {24'b0, spi_parallel_out}, {24'b0, exp_word(8'hD6)});
    check_eq("glitch_fin_cnt", fin_cnt, 32'd5);

    repeat (3) @(negedge clk);
    check_eq("fin_idle", {31'b0, finished}, 32'd0);
    check_eq("fin_single_cycle", fin_double, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
